clock_bram_refcnt: RTL and testbench

- Single-clock BRAM for key/value storage; each entry carries a parametrised saturating reference counter instead of a single access bit.
- Port B is the data port: reads increment the counter, writes store data and clear it.
- A built-in CLOCK-sweep victim finder replaces the bit read/clear port. On request it returns the next entry whose counter is zero, decrementing the counters it passes.
- Sits in the memcached cache datapath, supplying eviction candidates to the insert logic.

---
 rtl/clock_bram_pkg.sv | 42 ++++
 rtl/clock_bram_sweeper.sv | 147 ++++++++++++++
 rtl/clock_bram_refcnt.sv | 180 ++++++++++++++++++
 tb/tb_clock_bram_refcnt.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_bram_pkg.sv
// Shared definitions for the CLOCK-sweep key/value BRAM.
// Contents:
//   sweep_state_e   - sweeper FSM states (INIT, IDLE, SCAN, DONE)
//   MAX_SCAN_FACTOR - default scan limit expressed as passes over the array
//   cnt_sat_inc     - saturating reference-counter increment
//   cnt_dec         - reference-counter decrement that stops at zero
// Counter helpers operate on CNT_W_MAX-bit values; callers zero-extend their
// narrower counters and truncate the result back.
package clock_bram_pkg;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_SCAN = 2'd2,
    ST_DONE = 2'd3
  } sweep_state_e;

  localparam int MAX_SCAN_FACTOR = 4;
  localparam int CNT_W_MAX       = 8;

  function automatic logic [CNT_W_MAX-1:0] cnt_sat_inc(
    input logic [CNT_W_MAX-1:0] cnt,
    input logic [CNT_W_MAX-1:0] cnt_max
  );
    if (cnt >= cnt_max) begin
      cnt_sat_inc = cnt_max;
    end else begin
      cnt_sat_inc = cnt + 8'd1;
    end
  endfunction

  function automatic logic [CNT_W_MAX-1:0] cnt_dec(
    input logic [CNT_W_MAX-1:0] cnt
  );
    if (cnt == 8'd0) begin
      cnt_dec = 8'd0;
    end else begin
      cnt_dec = cnt - 8'd1;
    end
  endfunction

endpackage

// File: rtl/clock_bram_sweeper.sv
// CLOCK-sweep victim finder.
// Owns the hand pointer, the scan budget counter and the victim handshake.
// During INIT the hand doubles as the counter-clear index, so it naturally
// lands back on 0 when initialisation completes.
// Ports:
//   clk, resetn          - clock, asynchronous active-low reset
//   victim_req           - level request to start a scan
//   victim_ready         - consumer accepts the presented victim
//   en, addr             - data-port activity, used to mask collisions
//   cnt_at_hand          - current counter value at the hand
//   hand                 - entry currently pointed at
//   clr_en               - clear cnt[hand] (initialisation)
//   dec_en               - decrement cnt[hand] (sweep)
//   init_done            - initialisation complete
//   victim_valid/addr/forced - victim presentation
module clock_bram_sweeper
  import clock_bram_pkg::*;
#(
  parameter int L2_DEPTH  = 8,
  parameter int CNT_WIDTH = 2,
  parameter int MAX_SCAN  = 1024
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 victim_req,
  input  logic                 victim_ready,
  input  logic                 en,
  input  logic [L2_DEPTH-1:0]  addr,
  input  logic [CNT_WIDTH-1:0] cnt_at_hand,
  output logic [L2_DEPTH-1:0]  hand,
  output logic                 clr_en,
  output logic                 dec_en,
  output logic                 init_done,
  output logic                 victim_valid,
  output logic [L2_DEPTH-1:0]  victim_addr,
  output logic                 victim_forced
);

  localparam int                    SCAN_W    = $clog2(MAX_SCAN) + 1;
  localparam logic [SCAN_W-1:0]     SCAN_LAST = SCAN_W'(MAX_SCAN - 1);
  localparam logic [L2_DEPTH-1:0]   HAND_LAST = {L2_DEPTH{1'b1}};
  localparam logic [L2_DEPTH-1:0]   HAND_ONE  = L2_DEPTH'(1'b1);

  sweep_state_e          state_q, state_d;
  logic [L2_DEPTH-1:0]   hand_q, hand_d;
  logic [SCAN_W-1:0]     scan_q, scan_d;
  logic                  init_done_q, init_done_d;
  logic                  valid_q, valid_d;
  logic [L2_DEPTH-1:0]   vaddr_q, vaddr_d;
  logic                  forced_q, forced_d;
  logic                  collide_s;

  // Next-state logic for the sweeper FSM, hand, scan budget and victim.
  always_comb begin
    state_d     = state_q;
    hand_d      = hand_q;
    scan_d      = scan_q;
    init_done_d = init_done_q;
    valid_d     = valid_q;
    vaddr_d     = vaddr_q;
    forced_d    = forced_q;
    clr_en      = 1'b0;
    dec_en      = 1'b0;
    // The data port owns the entry this cycle; the sweeper must not touch
    // or select it, but still moves past it.
    collide_s   = en && (addr == hand_q);
    case (state_q)
      ST_INIT: begin
        clr_en = 1'b1;
        hand_d = hand_q + HAND_ONE;
        if (hand_q == HAND_LAST) begin
          state_d     = ST_IDLE;
          init_done_d = 1'b1;
        end else begin
          state_d     = ST_INIT;
        end
      end
      ST_IDLE: begin
        if (init_done_q && victim_req) begin
          state_d = ST_SCAN;
          scan_d  = {SCAN_W{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SCAN: begin
        hand_d = hand_q + HAND_ONE;
        if (!collide_s && (cnt_at_hand == {CNT_WIDTH{1'b0}})) begin
          vaddr_d  = hand_q;
          forced_d = 1'b0;
          valid_d  = 1'b1;
          state_d  = ST_DONE;
        end else begin
          dec_en = !collide_s;
          // The entry examined as the last of the budget is taken regardless.
          if (scan_q == SCAN_LAST) begin
            vaddr_d  = hand_q;
            forced_d = 1'b1;
            valid_d  = 1'b1;
            state_d  = ST_DONE;
          end else begin
            scan_d   = scan_q + SCAN_W'(1'b1);
          end
        end
      end
      ST_DONE: begin
        if (victim_ready) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // Sweeper state registers with asynchronous reset back to INIT.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_INIT;
      hand_q      <= {L2_DEPTH{1'b0}};
      scan_q      <= {SCAN_W{1'b0}};
      init_done_q <= 1'b0;
      valid_q     <= 1'b0;
      vaddr_q     <= {L2_DEPTH{1'b0}};
      forced_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      hand_q      <= hand_d;
      scan_q      <= scan_d;
      init_done_q <= init_done_d;
      valid_q     <= valid_d;
      vaddr_q     <= vaddr_d;
      forced_q    <= forced_d;
    end
  end

  assign hand          = hand_q;
  assign init_done     = init_done_q;
  assign victim_valid  = valid_q;
  assign victim_addr   = vaddr_q;
  assign victim_forced = forced_q;

endmodule

// File: rtl/clock_bram_refcnt.sv
// Key/value BRAM with per-entry saturating reference counters and a built-in
// CLOCK-sweep victim finder feeding eviction candidates to insert logic.
// Ports:
//   clk, resetn   - clock, asynchronous active-low reset
//   en, we, addr, din, regce, dout - write-first data port, 2-cycle read
//   init_done     - counter initialisation complete
//   victim_req/valid/ready/addr/forced - victim request and handshake
//   stat_victims, stat_forced - delivered / forced victim counts
// Optional feature: define CLOCK_BRAM_REFCNT_STATS_EN to build the statistics
// counters; otherwise both stat ports read as zero.
// The data array relies on the FPGA configuration image for its zero start
// value and is deliberately not touched by reset.
module clock_bram_refcnt
  import clock_bram_pkg::*;
#(
  parameter int L2_DEPTH  = 8,
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 2,
  parameter int MAX_SCAN  = MAX_SCAN_FACTOR * (2 ** L2_DEPTH)
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                en,
  input  logic                we,
  input  logic [L2_DEPTH-1:0] addr,
  input  logic [WIDTH-1:0]    din,
  input  logic                regce,
  output logic [WIDTH-1:0]    dout,
  output logic                init_done,
  input  logic                victim_req,
  output logic                victim_valid,
  input  logic                victim_ready,
  output logic [L2_DEPTH-1:0] victim_addr,
  output logic                victim_forced,
  output logic [31:0]         stat_victims,
  output logic [31:0]         stat_forced
);

  localparam int                   DEPTH   = 2 ** L2_DEPTH;
  localparam logic [CNT_W_MAX-1:0] CNT_MAX = CNT_W_MAX'((2 ** CNT_WIDTH) - 1);

  logic [WIDTH-1:0]     mem_q [DEPTH];
  logic [CNT_WIDTH-1:0] cnt_q [DEPTH];
  logic [WIDTH-1:0]     stage1_q, stage1_d;
  logic [WIDTH-1:0]     dout_q, dout_d;

  logic [L2_DEPTH-1:0]  hand_s;
  logic                 clr_en_s, dec_en_s, init_done_s;
  logic                 victim_valid_s, victim_forced_s;
  logic [L2_DEPTH-1:0]  victim_addr_s;
  logic                 port_cnt_we_s;
  logic [CNT_WIDTH-1:0] port_cnt_val_s, dec_val_s;

  clock_bram_sweeper #(
    .L2_DEPTH  (L2_DEPTH),
    .CNT_WIDTH (CNT_WIDTH),
    .MAX_SCAN  (MAX_SCAN)
  ) u_sweeper (
    .clk           (clk),
    .resetn        (resetn),
    .victim_req    (victim_req),
    .victim_ready  (victim_ready),
    .en            (en),
    .addr          (addr),
    .cnt_at_hand   (cnt_q[hand_s]),
    .hand          (hand_s),
    .clr_en        (clr_en_s),
    .dec_en        (dec_en_s),
    .init_done     (init_done_s),
    .victim_valid  (victim_valid_s),
    .victim_addr   (victim_addr_s),
    .victim_forced (victim_forced_s)
  );

  // Data-port pipeline: write-first stage 1, then regce-gated output stage.
  always_comb begin
    if (en) begin
      if (we) begin
        stage1_d = din;
      end else begin
        stage1_d = mem_q[addr];
      end
    end else begin
      stage1_d = stage1_q;
    end
    if (regce) begin
      dout_d = stage1_q;
    end else begin
      dout_d = dout_q;
    end
  end

  // Counter update values for the data port and the sweeper decrement.
  always_comb begin
    // Port counter updates are ignored until initialisation has finished.
    port_cnt_we_s = en && init_done_s;
    if (we) begin
      port_cnt_val_s = {CNT_WIDTH{1'b0}};
    end else begin
      port_cnt_val_s = CNT_WIDTH'(cnt_sat_inc(CNT_W_MAX'(cnt_q[addr]), CNT_MAX));
    end
    dec_val_s = CNT_WIDTH'(cnt_dec(CNT_W_MAX'(cnt_q[hand_s])));
  end

  // Data array write (BRAM, no reset).
  always_ff @(posedge clk) begin
    if (en && we) begin
      mem_q[addr] <= din;
    end
  end

  // Counter array; the port write is last so it wins on a shared index.
  always_ff @(posedge clk) begin
    if (clr_en_s) begin
      cnt_q[hand_s] <= {CNT_WIDTH{1'b0}};
    end else begin
      if (dec_en_s) begin
        cnt_q[hand_s] <= dec_val_s;
      end
      if (port_cnt_we_s) begin
        cnt_q[addr] <= port_cnt_val_s;
      end
    end
  end

  // Data-port pipeline registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stage1_q <= {WIDTH{1'b0}};
      dout_q   <= {WIDTH{1'b0}};
    end else begin
      stage1_q <= stage1_d;
      dout_q   <= dout_d;
    end
  end

  assign dout          = dout_q;
  assign init_done     = init_done_s;
  assign victim_valid  = victim_valid_s;
  assign victim_addr   = victim_addr_s;
  assign victim_forced = victim_forced_s;

`ifdef CLOCK_BRAM_REFCNT_STATS_EN
  logic [31:0] stat_victims_q, stat_victims_d;
  logic [31:0] stat_forced_q, stat_forced_d;

  // Statistics count each accepted victim and the forced subset.
  always_comb begin
    if (victim_valid_s && victim_ready) begin
      stat_victims_d = stat_victims_q + 32'd1;
      if (victim_forced_s) begin
        stat_forced_d = stat_forced_q + 32'd1;
      end else begin
        stat_forced_d = stat_forced_q;
      end
    end else begin
      stat_victims_d = stat_victims_q;
      stat_forced_d  = stat_forced_q;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stat_victims_q <= 32'd0;
      stat_forced_q  <= 32'd0;
    end else begin
      stat_victims_q <= stat_victims_d;
      stat_forced_q  <= stat_forced_d;
    end
  end

  assign stat_victims = stat_victims_q;
  assign stat_forced  = stat_forced_q;
`else
  assign stat_victims = 32'd0;
  assign stat_forced  = 32'd0;
`endif

endmodule

// File: tb/tb_clock_bram_refcnt.sv
// Self-checking bench for clock_bram_refcnt: directed scenarios plus random
// traffic, all compared against a behavioural model of the storage, the
// reference counters and the victim search.
module tb_clock_bram_refcnt;

  localparam int DEPTH    = 256;
  localparam int CNT_MAXV = 3;
  localparam int MAX_SCAN = 1024;
  localparam int M_INIT = 0, M_IDLE = 1, M_SCAN = 2, M_DONE = 3;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        en = 1'b0, we = 1'b0, regce = 1'b0;
  logic [7:0]  addr = 8'd0;
  logic [31:0] din = 32'd0;
  logic        victim_req = 1'b0, victim_ready = 1'b0;
  logic [31:0] dout;
  logic        init_done, victim_valid, victim_forced;
  logic [7:0]  victim_addr;
  logic [31:0] stat_victims, stat_forced;

  clock_bram_refcnt dut (
    .clk           (clk),
    .resetn        (resetn),
    .en            (en),
    .we            (we),
    .addr          (addr),
    .din           (din),
    .regce         (regce),
    .dout          (dout),
    .init_done     (init_done),
    .victim_req    (victim_req),
    .victim_valid  (victim_valid),
    .victim_ready  (victim_ready),
    .victim_addr   (victim_addr),
    .victim_forced (victim_forced),
    .stat_victims  (stat_victims),
    .stat_forced   (stat_forced)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  logic [31:0] mem_m [DEPTH];
  int          cnt_m [DEPTH];
  int          mode_m, hand_m, init_idx_m, examined_m, vaddr_m;
  bit          init_done_m, vval_m, vforced_m;
  logic [31:0] st1_m, dout_m;
  int unsigned stv_m, stf_m;

  int errors = 0;
  int checks = 0;
  int captured;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    mode_m = M_INIT; hand_m = 0; init_idx_m = 0; examined_m = 0;
    vaddr_m = 0; init_done_m = 0; vval_m = 0; vforced_m = 0;
    st1_m = 32'd0; dout_m = 32'd0; stv_m = 0; stf_m = 0;
  endtask

  task automatic report_victim(input bit forced);
    vaddr_m = hand_m; vforced_m = forced; vval_m = 1; mode_m = M_DONE;
  endtask

  // One clock of model behaviour using the inputs present at the edge.
  task automatic model_update();
    bit was_init, collide;
    logic [31:0] new_st1;
    if (!resetn) begin
      model_reset();
      return;
    end
    was_init = (mode_m == M_INIT);
    case (mode_m)
      M_INIT: begin
        cnt_m[init_idx_m] = 0;
        init_idx_m++;
        if (init_idx_m == DEPTH) begin init_done_m = 1; mode_m = M_IDLE; end
      end
      M_IDLE: if (victim_req) begin mode_m = M_SCAN; examined_m = 0; end
      M_SCAN: begin
        collide = en && (int'(addr) == hand_m);
        if (!collide && cnt_m[hand_m] == 0) begin
          report_victim(0);
        end else begin
          if (!collide && cnt_m[hand_m] > 0) cnt_m[hand_m]--;
          examined_m++;
          if (examined_m == MAX_SCAN) report_victim(1);
        end
        hand_m = (hand_m + 1) % DEPTH;
      end
      default: if (victim_ready) begin
        vval_m = 0; mode_m = M_IDLE; stv_m++;
        if (vforced_m) stf_m++;
      end
    endcase
    new_st1 = st1_m;
    if (en) begin
      if (we) begin
        mem_m[addr] = din;
        new_st1 = din;
      end else begin
        new_st1 = mem_m[addr];
      end
      if (!was_init) begin
        if (we) cnt_m[addr] = 0;
        else if (cnt_m[addr] < CNT_MAXV) cnt_m[addr]++;
      end
    end
    if (regce) dout_m = st1_m;
    st1_m = new_st1;
  endtask

  task automatic compare_all();
    check_value("dout", dout, dout_m);
    check_value("init_done", {31'd0, init_done}, {31'd0, init_done_m});
    check_value("victim_valid", {31'd0, victim_valid}, {31'd0, vval_m});
    check_value("victim_addr", {24'd0, victim_addr}, 32'(vaddr_m));
    check_value("victim_forced", {31'd0, victim_forced}, {31'd0, vforced_m});
`ifdef CLOCK_BRAM_REFCNT_STATS_EN
    check_value("stat_victims", stat_victims, stv_m);
    check_value("stat_forced", stat_forced, stf_m);
`else
    check_value("stat_victims", stat_victims, 32'd0);
    check_value("stat_forced", stat_forced, 32'd0);
`endif
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    model_update();
    compare_all();
  endtask

  task automatic wait_victim(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (victim_valid) break;
      cycle();
    end
    check_value("victim_seen", {31'd0, victim_valid}, 32'd1);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin mem_m[i] = 32'd0; cnt_m[i] = 0; end
    model_reset();
    repeat (3) cycle();
    check_value("rst_init_done", {31'd0, init_done}, 32'd0);
    check_value("rst_valid", {31'd0, victim_valid}, 32'd0);

    // Initialisation takes exactly DEPTH cycles after release.
    resetn = 1'b1;
    repeat (DEPTH - 1) cycle();
    check_value("init_not_yet", {31'd0, init_done}, 32'd0);
    cycle();
    check_value("init_done_at_depth", {31'd0, init_done}, 32'd1);

    // Saturate addr 0; first victim must be addr 1.
    en = 1'b1; we = 1'b0; addr = 8'd0; regce = 1'b1;
    repeat (4) cycle();
    en = 1'b0; victim_req = 1'b1;
    wait_victim(20);
    check_value("sat_victim_addr", {24'd0, victim_addr}, 32'd1);
    check_value("sat_victim_forced", {31'd0, victim_forced}, 32'd0);
    victim_req = 1'b0; victim_ready = 1'b1;
    cycle();
    check_value("sat_valid_drop", {31'd0, victim_valid}, 32'd0);
    victim_ready = 1'b0;

    // Write then read addr 5; write-first on addr 6.
    en = 1'b1; we = 1'b1; addr = 8'd5; din = 32'hA5A5A5A5;
    cycle();
    we = 1'b0;
    cycle();
    en = 1'b0;
    cycle();
    check_value("read_addr5", dout, 32'hA5A5A5A5);
    en = 1'b1; we = 1'b1; addr = 8'd6; din = 32'h600DF00D;
    cycle();
    en = 1'b0; we = 1'b0;
    cycle();
    check_value("write_first_addr6", dout, 32'h600DF00D);

    // Victim held while the consumer stalls.
    victim_req = 1'b1;
    wait_victim(600);
    victim_req = 1'b0;
    captured = int'(victim_addr);
    repeat (10) begin
      cycle();
      check_value("stall_addr", {24'd0, victim_addr}, 32'(captured));
      check_value("stall_valid", {31'd0, victim_valid}, 32'd1);
    end
    victim_ready = 1'b1;
    cycle();
    check_value("stall_release", {31'd0, victim_valid}, 32'd0);
    victim_ready = 1'b0;

    // Every entry saturated and the hand constantly hit: forced victim.
    en = 1'b1; we = 1'b0;
    for (int a = 0; a < DEPTH; a++) begin
      addr = 8'(a);
      repeat (3) cycle();
    end
    victim_req = 1'b1;
    for (int i = 0; i < MAX_SCAN + 100; i++) begin
      if (victim_valid) break;
      addr = 8'(hand_m);
      cycle();
    end
    en = 1'b0;
    check_value("forced_seen", {31'd0, victim_valid}, 32'd1);
    check_value("forced_flag", {31'd0, victim_forced}, 32'd1);
    victim_req = 1'b0; victim_ready = 1'b1;
    cycle();
    victim_ready = 1'b0;
`ifdef CLOCK_BRAM_REFCNT_STATS_EN
    check_value("stat_forced_one", stat_forced, 32'd1);
`endif

    // Random traffic.
    repeat (3000) begin
      en = 1'($urandom_range(0, 1));
      we = ($urandom_range(0, 3) == 0);
      addr = 8'($urandom);
      din = $urandom;
      regce = ($urandom_range(0, 7) != 0);
      victim_req = ($urandom_range(0, 3) != 0);
      victim_ready = 1'($urandom_range(0, 1));
      cycle();
    end

    // Reset in the middle of a scan.
    en = 1'b0; we = 1'b0; regce = 1'b1; victim_ready = 1'b1; victim_req = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if (mode_m == M_SCAN) break;
      cycle();
    end
    resetn = 1'b0;
    #1;
    check_value("midscan_valid", {31'd0, victim_valid}, 32'd0);
    check_value("midscan_init_done", {31'd0, init_done}, 32'd0);
    model_reset();
    victim_req = 1'b0; victim_ready = 1'b0;
    repeat (2) cycle();
    resetn = 1'b1;
    repeat (DEPTH) cycle();
    check_value("reinit_done", {31'd0, init_done}, 32'd1);
    victim_req = 1'b1;
    cycle();
    cycle();
    check_value("first_victim_valid", {31'd0, victim_valid}, 32'd1);
    check_value("first_victim_addr", {24'd0, victim_addr}, 32'd0);
    check_value("first_victim_forced", {31'd0, victim_forced}, 32'd0);
    victim_req = 1'b0; victim_ready = 1'b1;
    cycle();
    victim_ready = 1'b0;
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
